// File: rtl/sound_mixer_att.sv
// Multi-channel sound mixer with per-channel EXT/INT gain (MUL / 2^SHIFT, mute) and one shared MAC.
// Optional peak meters are built when SOUND_MIXER_PEAK_EN is defined.
module sound_mixer_att #(
    parameter int NUM_CH        = 4,
    parameter int IN_WIDTH      = 10,
    parameter int OUT_WIDTH     = 10,
    parameter int DEF_EXT_MUL   = 1,
    parameter int DEF_EXT_SHIFT = 0,
    parameter int DEF_INT_MUL   = 9,
    parameter int DEF_INT_SHIFT = 2
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [NUM_CH*IN_WIDTH-1:0]   IN_DATA,
    input  logic                         SAMPLE_REQ,
    input  logic                         REG_WE,
    input  logic [$clog2(NUM_CH):0]      REG_ADDR,
    input  logic [6:0]                   REG_WDATA,
    output logic [6:0]                   REG_RDATA,
    output logic [OUT_WIDTH-1:0]         OUT_EXT,
    output logic [OUT_WIDTH-1:0]         OUT_INT,
    output logic                         OUT_VALID,
    output logic                         OVERRUN,
    input  logic                         PEAK_CLR,
    output logic [OUT_WIDTH-2:0]         PEAK_EXT,
    output logic [OUT_WIDTH-2:0]         PEAK_INT
);

    localparam int CW  = $clog2(NUM_CH);
    localparam int TW  = IN_WIDTH + 4;
    localparam int ACW = TW + CW;

    localparam logic [6:0] DEF_EXT = {1'b0, 2'(DEF_EXT_SHIFT), 4'(DEF_EXT_MUL)};
    localparam logic [6:0] DEF_INT = {1'b0, 2'(DEF_INT_SHIFT), 4'(DEF_INT_MUL)};

    localparam logic signed [ACW-1:0] SAT_MAX = ACW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACW-1:0] SAT_MIN = ~SAT_MAX;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_ACCUM  = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;

    logic [6:0]          ext_gain_q [NUM_CH];
    logic [6:0]          int_gain_q [NUM_CH];
    logic [6:0]          ext_sh_q   [NUM_CH];
    logic [6:0]          int_sh_q   [NUM_CH];
    logic [IN_WIDTH-1:0] in_sh_q    [NUM_CH];

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         ch_q, ch_d;
    logic signed [ACW-1:0] acc_ext_q, acc_ext_d, acc_int_q, acc_int_d;
    logic [OUT_WIDTH-1:0]  out_ext_q, out_ext_d, out_int_q, out_int_d;
    logic                  out_valid_q, out_valid_d;
    logic                  overrun_q, overrun_d;
    logic [6:0]            rdata_q, rdata_d;
    logic signed [TW-1:0]  term_ext, term_int;

    logic [CW-1:0] reg_ch;
    logic          reg_sel;
    logic          addr_ok;

    assign reg_ch  = REG_ADDR[CW:1];
    assign reg_sel = REG_ADDR[0];
    assign addr_ok = ({1'b0, reg_ch} < (CW + 1)'(NUM_CH));

    function automatic logic signed [TW-1:0] gain_term(input logic [IN_WIDTH-1:0] s,
                                                       input logic [6:0] g);
        logic signed [TW-1:0] s_ext;
        logic signed [TW-1:0] m_ext;
        logic signed [TW-1:0] prod;
        s_ext = {{4{s[IN_WIDTH-1]}}, s};
        m_ext = {{(TW - 4){1'b0}}, g[3:0]};
        prod  = s_ext * m_ext;
        if (g[6])
            gain_term = '0;
        else
            gain_term = prod >>> g[5:4];
    endfunction

    function automatic logic [OUT_WIDTH-1:0] saturate(input logic signed [ACW-1:0] a);
        if (a > SAT_MAX)
            saturate = SAT_MAX[OUT_WIDTH-1:0];
        else if (a < SAT_MIN)
            saturate = SAT_MIN[OUT_WIDTH-1:0];
        else
            saturate = a[OUT_WIDTH-1:0];
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ext_gain_q[i] <= DEF_EXT;
                int_gain_q[i] <= DEF_INT;
            end
        end else if (REG_WE && addr_ok) begin
            if (reg_sel)
                int_gain_q[reg_ch] <= REG_WDATA;
            else
                ext_gain_q[reg_ch] <= REG_WDATA;
        end
    end

    // Write data is forwarded so a write is visible on the very next cycle.
    always_comb begin
        rdata_d = '0;
        if (addr_ok) begin
            if (REG_WE)
                rdata_d = REG_WDATA;
            else if (reg_sel)
                rdata_d = int_gain_q[reg_ch];
            else
                rdata_d = ext_gain_q[reg_ch];
        end
    end

    always_ff @(posedge CLK) begin
        if (state_q == S_LOAD) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                in_sh_q[i]  <= IN_DATA[i*IN_WIDTH +: IN_WIDTH];
                ext_sh_q[i] <= ext_gain_q[i];
                int_sh_q[i] <= int_gain_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        acc_ext_d   = acc_ext_q;
        acc_int_d   = acc_int_q;
        out_ext_d   = out_ext_q;
        out_int_d   = out_int_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q | (SAMPLE_REQ && (state_q != S_IDLE));
        term_ext    = gain_term(in_sh_q[ch_q], ext_sh_q[ch_q]);
        term_int    = gain_term(in_sh_q[ch_q], int_sh_q[ch_q]);
        case (state_q)
            S_IDLE: begin
                if (SAMPLE_REQ)
                    state_d = S_LOAD;
            end
            S_LOAD: begin
                acc_ext_d = '0;
                acc_int_d = '0;
                ch_d      = '0;
                state_d   = S_ACCUM;
            end
            S_ACCUM: begin
                acc_ext_d = acc_ext_q + ACW'(term_ext);
                acc_int_d = acc_int_q + ACW'(term_int);
                ch_d      = ch_q + 1'b1;
                // Outputs are registered with the final sum so they are valid during OUTPUT.
                if (ch_q == CW'(NUM_CH - 1)) begin
                    state_d     = S_OUTPUT;
                    out_ext_d   = saturate(acc_ext_d);
                    out_int_d   = saturate(acc_int_d);
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            acc_ext_q   <= '0;
            acc_int_q   <= '0;
            out_ext_q   <= '0;
            out_int_q   <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            acc_ext_q   <= acc_ext_d;
            acc_int_q   <= acc_int_d;
            out_ext_q   <= out_ext_d;
            out_int_q   <= out_int_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            rdata_q     <= rdata_d;
        end
    end

    assign OUT_EXT   = out_ext_q;
    assign OUT_INT   = out_int_q;
    assign OUT_VALID = out_valid_q;
    assign OVERRUN   = overrun_q;
    assign REG_RDATA = rdata_q;

`ifdef SOUND_MIXER_PEAK_EN
    logic [OUT_WIDTH-2:0] peak_ext_q, peak_ext_d, peak_int_q, peak_int_d;
    logic [OUT_WIDTH-2:0] mag_ext, mag_int;

    // The most negative sample has no positive twin, so its magnitude clamps.
    function automatic logic [OUT_WIDTH-2:0] magnitude(input logic [OUT_WIDTH-1:0] v);
        logic [OUT_WIDTH-1:0] n;
        n = -v;
        if (!v[OUT_WIDTH-1])
            magnitude = v[OUT_WIDTH-2:0];
        else if (v[OUT_WIDTH-2:0] == '0)
            magnitude = '1;
        else
            magnitude = n[OUT_WIDTH-2:0];
    endfunction

    always_comb begin
        mag_ext    = magnitude(out_ext_q);
        mag_int    = magnitude(out_int_q);
        peak_ext_d = peak_ext_q;
        peak_int_d = peak_int_q;
        if (PEAK_CLR) begin
            peak_ext_d = '0;
            peak_int_d = '0;
        end else if (out_valid_q) begin
            if (mag_ext > peak_ext_q)
                peak_ext_d = mag_ext;
            if (mag_int > peak_int_q)
                peak_int_d = mag_int;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            peak_ext_q <= '0;
            peak_int_q <= '0;
        end else begin
            peak_ext_q <= peak_ext_d;
            peak_int_q <= peak_int_d;
        end
    end

    assign PEAK_EXT = peak_ext_q;
    assign PEAK_INT = peak_int_q;
`else
    logic unused_peak_clr;
    assign unused_peak_clr = PEAK_CLR;
    assign PEAK_EXT        = '0;
    assign PEAK_INT        = '0;
`endif

endmodule

// File: tb/tb_sound_mixer_att.sv
// Directed self-checking bench for sound_mixer_att (NUM_CH=4, 10-bit in/out).
module tb_sound_mixer_att;

    localparam int NCH = 4;
    localparam int IW  = 10;
    localparam int OW  = 10;

    logic                CLK = 1'b0;
    logic                RESET;
    logic [NCH*IW-1:0]   IN_DATA;
    logic                SAMPLE_REQ;
    logic                REG_WE;
    logic [2:0]          REG_ADDR;
    logic [6:0]          REG_WDATA;
    logic [6:0]          REG_RDATA;
    logic [OW-1:0]       OUT_EXT;
    logic [OW-1:0]       OUT_INT;
    logic                OUT_VALID;
    logic                OVERRUN;
    logic                PEAK_CLR;
    logic [OW-2:0]       PEAK_EXT;
    logic [OW-2:0]       PEAK_INT;

    int n_cmp = 0;
    int n_bad = 0;
    int lat   = 0;

    always #5 CLK = ~CLK;

    sound_mixer_att #(
        .NUM_CH   (NCH),
        .IN_WIDTH (IW),
        .OUT_WIDTH(OW)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IN_DATA   (IN_DATA),
        .SAMPLE_REQ(SAMPLE_REQ),
        .REG_WE    (REG_WE),
        .REG_ADDR  (REG_ADDR),
        .REG_WDATA (REG_WDATA),
        .REG_RDATA (REG_RDATA),
        .OUT_EXT   (OUT_EXT),
        .OUT_INT   (OUT_INT),
        .OUT_VALID (OUT_VALID),
        .OVERRUN   (OVERRUN),
        .PEAK_CLR  (PEAK_CLR),
        .PEAK_EXT  (PEAK_EXT),
        .PEAK_INT  (PEAK_INT)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        lat++;
    endtask

    task automatic set_in(input int a, input int b, input int c, input int d);
        IN_DATA = {IW'(d), IW'(c), IW'(b), IW'(a)};
    endtask

    task automatic wr(input int addr, input int data);
        REG_ADDR  = 3'(addr);
        REG_WDATA = 7'(data);
        REG_WE    = 1'b1;
        step();
        REG_WE    = 1'b0;
    endtask

    task automatic rd(input string tag, input int addr, input int exp);
        REG_ADDR = 3'(addr);
        step();
        check(tag, int'(REG_RDATA), exp);
    endtask

    task automatic req();
        SAMPLE_REQ = 1'b1;
        lat = 0;
        step();
        SAMPLE_REQ = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        while (OUT_VALID !== 1'b1 && lat < 40)
            step();
        check({tag, "_lat"}, lat, NCH + 2);
    endtask

    task automatic mix(input string tag, input int exp_ext, input int exp_int);
        req();
        wait_valid(tag);
        check({tag, "_ext"}, $signed(OUT_EXT), exp_ext);
        check({tag, "_int"}, $signed(OUT_INT), exp_int);
        step();
        check({tag, "_pulse"}, int'(OUT_VALID), 0);
    endtask

    initial begin
        int nv;
        RESET      = 1'b1;
        SAMPLE_REQ = 1'b0;
        REG_WE     = 1'b0;
        REG_ADDR   = '0;
        REG_WDATA  = '0;
        PEAK_CLR   = 1'b0;
        IN_DATA    = '0;
        repeat (3) step();
        check("rst_ext", int'(OUT_EXT), 0);
        check("rst_int", int'(OUT_INT), 0);
        check("rst_valid", int'(OUT_VALID), 0);
        check("rst_ovr", int'(OVERRUN), 0);
        check("rst_rdata", int'(REG_RDATA), 0);
        check("rst_pkext", int'(PEAK_EXT), 0);
        check("rst_pkint", int'(PEAK_INT), 0);
        RESET = 1'b0;

        rd("rd_ext0", 0, 'h01);
        rd("rd_int0", 1, 'h29);
        rd("rd_int3", 7, 'h29);

        // Defaults: EXT 4*100; INT 4*((100*9)>>>2) = 900 saturates.
        set_in(100, 100, 100, 100);
        mix("dflt", 400, 511);

        // Floor toward -inf: -3>>>1 = -2.
        wr(1, 'h11);
        wr(3, 'h40);
        wr(5, 'h40);
        wr(7, 'h40);
        rd("rd_wr", 1, 'h11);
        set_in(-3, 100, 100, 100);
        mix("floor", 297, -2);

        for (int i = 0; i < NCH; i++) wr(i * 2, 'h0F);
        set_in(-512, -512, -512, -512);
        mix("satn", -512, -256);
        set_in(511, 511, 511, 511);
        mix("satp", 511, 255);
`ifndef SOUND_MIXER_PEAK_EN
        check("pk_off_ext", int'(PEAK_EXT), 0);
        check("pk_off_int", int'(PEAK_INT), 0);
`endif

        // Gain write during ACCUM only affects the following sample.
        for (int i = 0; i < NCH; i++) wr(i * 2, 'h01);
        set_in(200, 10, 20, 30);
        req();
        step();
        wr(0, 'h00);
        wait_valid("mid");
        check("mid_ext", $signed(OUT_EXT), 260);
        check("mid_int", $signed(OUT_INT), 100);
        step();
        mix("after", 60, 100);
        mix("b2b", 60, 100);
        check("b2b_ovr", int'(OVERRUN), 0);

        set_in(1, 2, 3, 4);
        req();
        step();
        step();
        SAMPLE_REQ = 1'b1;
        step();
        SAMPLE_REQ = 1'b0;
        wait_valid("ovr");
        check("ovr_ext", $signed(OUT_EXT), 9);
        check("ovr_int", $signed(OUT_INT), 0);
        check("ovr_flag", int'(OVERRUN), 1);
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (OUT_VALID === 1'b1) nv++;
        end
        check("ovr_single", nv, 0);
        mix("ovr_next", 9, 0);
        check("ovr_sticky", int'(OVERRUN), 1);

`ifdef SOUND_MIXER_PEAK_EN
        wr(0, 'h01);
        PEAK_CLR = 1'b1;
        step();
        PEAK_CLR = 1'b0;
        set_in(-300, 0, 0, 0);
        mix("pk1", -300, -150);
        check("pk1_ext", int'(PEAK_EXT), 300);
        check("pk1_int", int'(PEAK_INT), 150);
        set_in(200, 0, 0, 0);
        mix("pk2", 200, 100);
        check("pk2_ext", int'(PEAK_EXT), 300);
        check("pk2_int", int'(PEAK_INT), 150);
        PEAK_CLR = 1'b1;
        step();
        PEAK_CLR = 1'b0;
        check("pkclr_ext", int'(PEAK_EXT), 0);
        check("pkclr_int", int'(PEAK_INT), 0);
        set_in(-512, 0, 0, 0);
        mix("pk3", -512, -256);
        check("pk3_ext", int'(PEAK_EXT), 511);
        check("pk3_int", int'(PEAK_INT), 256);
        set_in(-300, 0, 0, 0);
        req();
        wait_valid("pkc");
        PEAK_CLR = 1'b1;
        step();
        PEAK_CLR = 1'b0;
        check("pkc_ext", int'(PEAK_EXT), 0);
        check("pkc_int", int'(PEAK_INT), 0);
`endif

        // Reset in the middle of a mix must abort it silently.
        set_in(50, 50, 50, 50);
        req();
        step();
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (OUT_VALID === 1'b1) nv++;
        end
        check("abort_valid", nv, 0);
        check("abort_ovr", int'(OVERRUN), 0);
        check("abort_ext", int'(OUT_EXT), 0);
        rd("abort_rd0", 0, 'h01);
        rd("abort_rd1", 1, 'h29);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sound_mixer_att.md
Name: sound_mixer_att

Overview:
- Parametrised successor to the fixed compile-time PSG/FM/MEGAROM attenuator constants.
- Mixes NUM_CH signed sound sources into two outputs: EXT for the 3.5 mm jack and INT for the MSX body.
- Each channel has a runtime-programmable gain per output, MUL / 2^SHIFT, plus a mute bit.
- Uses one shared time-multiplexed multiply-accumulate, triggered once per DAC sample strobe; the DAC drivers sit downstream.

Parameters:
- NUM_CH, 4, number of input channels (2..8).
- IN_WIDTH, 10, signed input sample width (matches SOUND_BIT_WIDTH).
- OUT_WIDTH, 10, signed output width (matches DAC_BIT_WIDTH).
- DEF_EXT_MUL, 1, reset MUL for every EXT gain.
- DEF_EXT_SHIFT, 0, reset SHIFT for every EXT gain.
- DEF_INT_MUL, 9, reset MUL for every INT gain.
- DEF_INT_SHIFT, 2, reset SHIFT for every INT gain.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous active-high reset.
- IN_DATA  in  NUM_CH*IN_WIDTH  signed samples; channel k occupies [k*IN_WIDTH +: IN_WIDTH].
- SAMPLE_REQ  in  1  one-cycle strobe that starts a mix.
- REG_WE  in  1  gain register write enable.
- REG_ADDR  in  $clog2(NUM_CH)+1  {channel, sel}; sel 0 = EXT, 1 = INT.
- REG_WDATA  in  7  [3:0] MUL, [5:4] SHIFT, [6] MUTE.
- REG_RDATA  out  7  registered readback of the register at REG_ADDR.
- OUT_EXT  out  OUT_WIDTH  mixed EXT sample.
- OUT_INT  out  OUT_WIDTH  mixed INT sample.
- OUT_VALID  out  1  one-cycle pulse when OUT_EXT/OUT_INT update.
- OVERRUN  out  1  sticky: SAMPLE_REQ arrived while busy.
- PEAK_CLR  in  1  clears peak registers (optional feature).
- PEAK_EXT  out  OUT_WIDTH-1  peak magnitude, EXT (optional feature).
- PEAK_INT  out  OUT_WIDTH-1  peak magnitude, INT (optional feature).

Behaviour:
- Reset: every channel's gain registers return to the DEF_* values with MUTE=0. State goes to IDLE. OUT_EXT, OUT_INT, OUT_VALID, OVERRUN, REG_RDATA and PEAK_* all become 0. Reset asserted mid-mix aborts the mix; no OUT_VALID is produced.
- Register writes are accepted in any state. REG_RDATA shows the updated value 1 cycle after the write. Reads are 1-cycle latency.
- State machine: IDLE -> LOAD -> ACCUM -> OUTPUT -> IDLE.
- IDLE: SAMPLE_REQ=1 moves to LOAD.
- LOAD (1 cycle):
  - Snapshot IN_DATA and all gain registers into shadow registers.
  - Clear both accumulators; channel counter = 0.
  - Writes during the mix therefore take effect from the next SAMPLE_REQ.
- ACCUM (NUM_CH cycles, one channel per cycle, channel 0 first):
  - term = (in * MUL) >>> SHIFT, computed at IN_WIDTH+4 bits signed. MUL is unsigned 0..15. The shift is arithmetic and floors toward -inf.
  - A muted channel contributes 0.
  - Accumulator width is IN_WIDTH+4+$clog2(NUM_CH); it never overflows.
- OUTPUT (1 cycle):
  - Each accumulator is saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and registered onto OUT_EXT/OUT_INT.
  - OUT_VALID=1 for this cycle only.
  - Outputs hold their value until the next OUTPUT.
- Latency: SAMPLE_REQ at cycle t gives OUT_VALID at t+NUM_CH+2.
- SAMPLE_REQ outside IDLE (including the OUTPUT cycle) is ignored and sets OVERRUN. OVERRUN clears only on RESET.
- SAMPLE_REQ in the cycle right after OUTPUT (back in IDLE) is accepted normally.
- MUL=0 behaves exactly like mute. Full-scale inputs with MUL=15, SHIFT=0 must saturate, never wrap.

Optional Feature:
- Macro SOUND_MIXER_PEAK_EN.
- Defined:
  - On each OUT_VALID, PEAK_x = max(PEAK_x, |OUT_x|). The magnitude of the most negative value clamps to 2^(OUT_WIDTH-1)-1.
  - PEAK_CLR=1 sets both peaks to 0. If PEAK_CLR and OUT_VALID coincide, the clear wins.
- Not defined: PEAK_EXT and PEAK_INT are constant 0, PEAK_CLR is ignored, and no peak logic is synthesised.

Test Plan:
- Reset defaults: after reset, NUM_CH=4, all inputs = 100, SAMPLE_REQ -> OUT_VALID 6 cycles later, OUT_EXT=400, OUT_INT = 4*floor(900/4) = 4*225 = 900 saturates to 511.
- Negative floor: ch0 = -3, INT gain MUL=1 SHIFT=1, other channels muted -> OUT_INT = -2.
- Saturation: all channels = -512, EXT gain MUL=15 SHIFT=0 -> OUT_EXT = -512; all = +511 -> OUT_EXT = 511.
- Write mid-mix: write ch0 EXT MUL=0 during ACCUM -> current result uses the old gain; the next sample drops ch0's contribution.
- Overrun: second SAMPLE_REQ 3 cycles after the first -> OVERRUN=1, only one OUT_VALID, next request in IDLE accepted.
- Peak (with SOUND_MIXER_PEAK_EN): outputs -300 then 200 -> PEAK=300; PEAK_CLR -> 0; an output of -512 gives PEAK=511.
